uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Byte buffer placed directly downstream of the UART receiver.
- Captures each received byte on the receiver's one-cycle `rx_done` strobe and holds it in a circular FIFO.
- The host side drains the FIFO with a registered read interface.
- Reports fill level, full/empty, and a sticky overrun flag when bytes arrive faster than the host drains them.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, at least 2.
- ADDR_W, 4, pointer width; must equal log2(DEPTH).
- AF_THRESH, 12, almost-full threshold in entries; used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_valid  input  1  write strobe; connected to the receiver's `rx_done`; every high cycle is one write request.
- wr_data  input  8  byte to store; connected to the receiver's `data_out`; sampled when wr_valid=1.
- rd_en  input  1  read request from the host.
- rd_data  output  8  byte read out; registered.
- rd_valid  output  1  one-cycle pulse; rd_data holds a new byte this cycle.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- count  output  ADDR_W+1  current number of stored entries, 0..DEPTH.
- overrun  output  1  sticky; set when a write is dropped because the FIFO is full.
- overrun_clr  input  1  synchronous clear for overrun.
- almost_full  output  1  present only with UART_RX_FIFO_ALMOST_FULL_EN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - rd_data=8'h00, rd_valid=0, overrun=0, empty=1, full=0.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all contents immediately; no rd_valid pulse follows the release of reset.
- Pointers:
  - ADDR_W bits each, wrapping modulo DEPTH.
  - count is tracked separately, ADDR_W+1 bits.
- Write accepted when wr_valid=1 and (full=0, or rd_en=1 in the same cycle). On acceptance:
  - mem[wr_ptr]<=wr_data
  - wr_ptr<=wr_ptr+1
- Read accepted when rd_en=1 and empty=0. On acceptance:
  - rd_data<=mem[rd_ptr] on the next edge
  - rd_valid=1 for exactly that one following cycle
  - rd_ptr<=rd_ptr+1
- Read latency is 1 cycle: rd_en sampled at edge N, data and rd_valid visible after edge N.
- rd_en while empty: ignored. rd_data keeps its last value; rd_valid=0.
- count update per cycle:
  - +1 on write only
  - −1 on read only
  - unchanged on both or neither
- Simultaneous cases:
  - Full, wr_valid=1 and rd_en=1: both accepted, count stays DEPTH, overrun not set.
  - Empty, wr_valid=1 and rd_en=1: write accepted, read ignored (no fall-through), count becomes 1.
- Overrun:
  - wr_valid=1, full=1, rd_en=0: byte dropped, storage and pointers untouched, overrun<=1.
  - overrun stays high until overrun_clr=1.
  - If overrun_clr and a new drop occur in the same cycle, set wins and overrun stays 1.
- empty and full are decoded combinationally from the registered count; no extra latency.
- wr_valid held high for multiple cycles writes the same byte multiple times. The receiver guarantees single-cycle strobes.
- No internal state machine beyond the pointer and count datapath.
- The block must not drive X or Z onto rd_data at any time.

Optional Feature:
- Macro: UART_RX_FIFO_ALMOST_FULL_EN.
- Defined:
  - almost_full port exists.
  - almost_full=1 when count>=AF_THRESH, combinational from count.
  - Reset value 0.
  - Intended for flow control toward the far end.
- Not defined:
  - almost_full port and its logic are absent.
  - AF_THRESH is ignored.
  - All other behaviour is identical.

Test Plan:
- Reset then write 8'hA5, 8'h3C on separate cycles -> count=2, empty=0; two rd_en pulses -> rd_valid pulses with rd_data=8'hA5 then 8'h3C, then count=0, empty=1.
- Write 16 bytes 0x00..0x0F (DEPTH=16) -> full=1, count=16; 17th write 0xFF -> overrun=1, count=16; drain 16 -> data 0x00..0x0F in order with no 0xFF; overrun_clr -> overrun=0.
- Full FIFO, assert wr_valid=1 (0x77) and rd_en=1 in the same cycle -> rd_data=oldest byte, count stays 16, overrun=0; final drained byte is 0x77.
- Empty FIFO, wr_valid=1 (0x5A) and rd_en=1 in the same cycle -> no rd_valid, count=1; next rd_en -> rd_data=0x5A.
- Write and read 40 bytes (0x00..0x27) interleaved, pointers wrapping twice -> output sequence exactly 0x00..0x27, no overrun; rd_en when empty -> rd_valid stays 0, rd_data unchanged.
- Write 5 bytes, assert rst_n=0 mid-stream for 1 cycle -> count=0, empty=1, rd_data=0x00, overrun=0. With UART_RX_FIFO_ALMOST_FULL_EN and AF_THRESH=12: 11 writes -> almost_full=0; 12th write -> almost_full=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular byte FIFO behind the UART receiver, with sticky overrun.
// Define UART_RX_FIFO_ALMOST_FULL_EN to add the almost_full output.
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              overrun_clr
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    ,
    output logic              almost_full
`endif
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_CNT   = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    if (DEPTH < 2 || DEPTH != (1 << ADDR_W) ||
        AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_param_err
        $error("uart_rx_fifo: bad DEPTH/ADDR_W/AF_THRESH");
    end

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              wr_acc;
    logic              rd_acc;
    logic              drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    assign almost_full = (count_q >= AF_CNT);
`else
    logic unused_af;
    assign unused_af = ^AF_CNT;
`endif

    // A full FIFO still takes a write when the same cycle frees a slot.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_valid && (!full || rd_en);
    assign drop   = wr_valid && full && !rd_en;

    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo against a queue model.
// Directed test-plan sequences followed by randomized traffic.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int AF     = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_valid = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              rd_en = 1'b0;
    logic              overrun_clr = 1'b0;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overrun;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    logic              almost_full;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    bit         m_ov = 1'b0;
    logic [7:0] last_data = 8'h00;

    uart_rx_fifo #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .AF_THRESH(AF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_valid(wr_valid),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .empty(empty),
        .full(full),
        .count(count),
        .overrun(overrun),
        .overrun_clr(overrun_clr)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
        ,
        .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected byte.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_data = 8'h00;
        end else if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_unexpected: got %0h want no pulse", rd_data);
            end else begin
                chk("rd_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
            end
            last_data = rd_data;
        end else begin
            chk("rd_valid_idle", {31'h0, rd_valid}, 32'h0);
            chk("rd_data_hold", {24'h0, rd_data}, {24'h0, last_data});
        end
    end

    task automatic check_status();
        int n;
        n = model_q.size();
        chk("count", {27'h0, count}, n);
        chk("empty", {31'h0, empty}, {31'h0, n == 0});
        chk("full", {31'h0, full}, {31'h0, n == DEPTH});
        chk("overrun", {31'h0, overrun}, {31'h0, m_ov});
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
        chk("almost_full", {31'h0, almost_full}, {31'h0, n >= AF});
`endif
    endtask

    // One clock of stimulus; the model decides acceptance from FIFO occupancy.
    task automatic step(bit wv, logic [7:0] wd, bit re, bit oc);
        bit was_full;
        bit was_empty;
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        wr_valid    = wv;
        wr_data     = wd;
        rd_en       = re;
        overrun_clr = oc;
        if (re && !was_empty) exp_q.push_back(model_q.pop_front());
        if (wv && (!was_full || re)) model_q.push_back(wd);
        if (wv && was_full && !re) m_ov = 1'b1;
        else if (oc) m_ov = 1'b0;
        @(posedge clk);
        @(negedge clk);
        wr_valid    = 1'b0;
        rd_en       = 1'b0;
        overrun_clr = 1'b0;
        check_status();
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_count", {27'h0, count}, 32'h0);
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_full", {31'h0, full}, 32'h0);
        chk("rst_rd_data", {24'h0, rd_data}, 32'h0);
        chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
        model_q.delete();
        exp_q.delete();
        m_ov = 1'b0;
        last_data = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        do_reset();

        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("tp1_count", {27'h0, count}, 32'd2);
        chk("tp1_empty", {31'h0, empty}, 32'h0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("tp1_empty_after", {31'h0, empty}, 32'h1);

        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("tp2_full", {31'h0, full}, 32'h1);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("tp2_overrun", {31'h0, overrun}, 32'h1);
        chk("tp2_count", {27'h0, count}, 32'd16);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("tp2_ov_clr", {31'h0, overrun}, 32'h0);

        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("tp3_count", {27'h0, count}, 32'd16);
        chk("tp3_overrun", {31'h0, overrun}, 32'h0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("tp3_last", {24'h0, rd_data}, 32'h77);

        step(1'b1, 8'h5A, 1'b1, 1'b0);
        chk("tp4_count", {27'h0, count}, 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("tp4_data", {24'h0, rd_data}, 32'h5A);

        for (int i = 0; i < 40; i++) step(1'b1, 8'(i), i > 0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("tp5_last", {24'h0, rd_data}, 32'h27);

        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        do_reset();

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
        for (int i = 0; i < 11; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("af_11", {31'h0, almost_full}, 32'h0);
        step(1'b1, 8'h0B, 1'b0, 1'b0);
        chk("af_12", {31'h0, almost_full}, 32'h1);
        do_reset();
`endif

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 55,
                 8'($urandom),
                 $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 5);
        end
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
